edge_req_scheduler: RTL and testbench

Round-robin scheduler that shares one command resource (e.g. a calibration or move sequencer) between NUM_REQ asynchronous push-button or level requesters. Each requester input is synchronized and rise-edge detected, so a held input counts as one request. The request is latched as pending and served through a start/done handshake with a timeout watchdog. It sits between raw user inputs and the shared command datapath.

---
 rtl/sched_pkg.sv | 31 +++
 rtl/req_sync_edge.sv | 27 ++
 rtl/edge_req_scheduler.sv | 92 +++++++++
 tb/tb_edge_req_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types and helpers for the edge-triggered round-robin scheduler.
// rr_pick walks from last_id+1 with wrap so any requester count 2..8 works.
package sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    function automatic int rr_pick(
        input logic [7:0] pend,
        input int         last,
        input int         n
    );
        int   idx;
        int   sel;
        logic found;
        sel   = 0;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = (last + k) % n;
            if (k <= n && !found && pend[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/req_sync_edge.sv
// Multi-flop synchronizer for one asynchronous request level, followed by
// a rise detector so a held input yields a single one-cycle pulse.
module req_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign rise = chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/edge_req_scheduler.sv
// Round-robin arbiter sharing one command resource between edge requests,
// with start/done handshake and a watchdog that drops stuck transactions.
module edge_req_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_in,
    input  logic                       en,
    input  logic                       res_done,
    output logic                       res_start,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [NUM_REQ-1:0]         pending,
    output logic [NUM_REQ-1:0]         dropped,
    output logic                       timeout_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    state_t             state;
    logic [IW-1:0]      last_id;
    logic [TW-1:0]      timer;
    logic [NUM_REQ-1:0] rise;
    logic [NUM_REQ-1:0] clr;
    logic [7:0]         pend8;
    logic               tc_hit;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_sync
        req_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (req_in[i]),
            .rise(rise[i])
        );
    end

    always_comb begin
        pend8 = '0;
        pend8[NUM_REQ-1:0] = pending;
    end

    // Clearing the served bit loses to a same-cycle new edge on that bit.
    assign clr = (state == GRANT) ? (NUM_REQ'(1) << grant_id) : '0;

    assign tc_hit      = (timer == TW'(TIMEOUT_CYC - 1));
    assign res_start   = (state == GRANT);
    assign busy        = (state == GRANT) || (state == WAIT);
    assign dropped     = rise & pending & ~clr;
    assign timeout_err = (state == WAIT) && !res_done && tc_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= '0;
            last_id  <= IW'(NUM_REQ - 1);
            timer    <= '0;
            pending  <= '0;
        end else begin
            pending <= (pending & ~clr) | rise;
            unique case (state)
                IDLE: begin
                    if (en && |pending) begin
                        grant_id <= IW'(rr_pick(pend8, int'(last_id), NUM_REQ));
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (res_done || tc_hit) begin
                        state   <= IDLE;
                        last_id <= grant_id;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_req_scheduler.sv
// Random stimulus against a transaction-level model of the scheduler,
// plus directed latency, round-robin and async reset scenarios.
module tb_edge_req_scheduler;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int TC = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_in;
    logic       en;
    logic       res_done;
    logic       res_start;
    logic [1:0] grant_id;
    logic       busy;
    logic [3:0] pending;
    logic [3:0] dropped;
    logic       timeout_err;

    edge_req_scheduler #(
        .NUM_REQ    (N),
        .SYNC_STAGES(S),
        .TIMEOUT_CYC(TC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .en         (en),
        .res_done   (res_done),
        .res_start  (res_start),
        .grant_id   (grant_id),
        .busy       (busy),
        .pending    (pending),
        .dropped    (dropped),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Model: history of sampled inputs, pending flags, and the transaction
    // in flight described by who is served and how many cycles it has run.
    logic [3:0] samp[$];
    logic [3:0] m_pend;
    int         m_srv;
    int         m_age;
    int         m_last;
    int         m_gid;
    int         cyc;
    int         start_cyc;
    int         start_gid;
    int         n_to;
    int         n_drop;

    task automatic m_reset();
        samp.delete();
        m_pend = '0;
        m_srv  = -1;
        m_age  = 0;
        m_last = N - 1;
        m_gid  = 0;
    endtask

    function automatic logic [3:0] m_edges();
        int         l;
        logic [3:0] so;
        logic [3:0] pv;
        l  = samp.size();
        so = (l >= S) ? samp[l-S] : 4'b0;
        pv = (l >= S + 1) ? samp[l-S-1] : 4'b0;
        return so & ~pv;
    endfunction

    task automatic check_outputs();
        logic [3:0] e;
        logic [3:0] drop_m;
        logic       bm;
        logic       sm;
        logic       tm;
        e  = m_edges();
        bm = (m_srv >= 0);
        sm = bm && (m_age == 0);
        drop_m = '0;
        for (int i = 0; i < N; i++)
            drop_m[i] = e[i] && m_pend[i] && !(sm && i == m_gid);
        tm = bm && (m_age == TC) && !res_done;
        check("busy", busy, bm);
        check("res_start", res_start, sm);
        check("pending", pending, m_pend);
        check("dropped", dropped, drop_m);
        check("timeout_err", timeout_err, tm);
        if (bm) check("grant_id", grant_id, m_gid);
        if (tm) n_to++;
        if (|drop_m) n_drop++;
        if (res_start) begin
            start_cyc = cyc;
            start_gid = grant_id;
        end
    endtask

    task automatic model_step();
        logic [3:0] e;
        logic [3:0] np;
        e  = m_edges();
        np = m_pend;
        for (int i = 0; i < N; i++) begin
            if (m_srv >= 0 && m_age == 0 && i == m_gid) np[i] = 1'b0;
            if (e[i]) np[i] = 1'b1;
        end
        if (m_srv < 0) begin
            if (en && |m_pend) begin
                for (int k = N; k >= 1; k--)
                    if (m_pend[(m_last + k) % N]) m_gid = (m_last + k) % N;
                m_srv = m_gid;
                m_age = 0;
            end
        end else if (m_age >= 1 && (res_done || m_age == TC)) begin
            m_srv  = -1;
            m_last = m_gid;
        end else begin
            m_age++;
        end
        m_pend = np;
        samp.push_back(req_in);
        if (samp.size() > S + 1) void'(samp.pop_front());
    endtask

    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
    endtask

    int t0;

    initial begin
        cyc = 0; n_to = 0; n_drop = 0;
        start_cyc = -1; start_gid = 0;
        rst = 1'b1; req_in = '0; en = 1'b0; res_done = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_pending", pending, 4'b0);
        check("rst_grant_id", grant_id, 2'd0);
        check("rst_start", res_start, 1'b0);
        check("rst_dropped", dropped, 4'b0);
        check("rst_timeout", timeout_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Single request: four-cycle latency to start, done after 3 cycles.
        en = 1'b1;
        req_in = 4'b0100;
        t0 = cyc;
        start_cyc = -1;
        for (int i = 0; i < 10; i++) if (start_cyc < 0) tick();
        check("t1_start_seen", start_cyc >= 0, 1'b1);
        check("t1_latency", start_cyc - t0, 4);
        check("t1_grant_id", start_gid, 2);
        tick();
        tick();
        res_done = 1'b1;
        tick();
        res_done = 1'b0;
        #1;
        check("t1_busy_after", busy, 1'b0);
        check("t1_pend_after", pending, 4'b0);
        req_in = '0;
        repeat (4) tick();

        // Randomized traffic with occasional enable drops and timeouts.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                int b;
                b = $urandom_range(0, 3);
                req_in[b] = ~req_in[b];
            end
            en = ($urandom_range(0, 9) != 0);
            res_done = ($urandom_range(0, 6) == 0);
            tick();
        end
        check("saw_timeout", n_to > 0, 1'b1);
        check("saw_drop", n_drop > 0, 1'b1);

        // Async reset in the middle of a wait.
        res_done = 1'b0;
        en = 1'b1;
        req_in = 4'b1010;
        for (int i = 0; i < 200; i++) if (!(m_srv >= 0 && m_age >= 2)) tick();
        check("mid_wait_busy", busy, 1'b1);
        req_in = '0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_grant_id", grant_id, 2'd0);
        check("arst_pending", pending, 4'b0);
        check("arst_start", res_start, 1'b0);
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) tick();
        req_in = 4'b1111;
        start_cyc = -1;
        for (int i = 0; i < 10; i++) if (start_cyc < 0) tick();
        check("post_rst_start_seen", start_cyc >= 0, 1'b1);
        check("post_rst_first_id", start_gid, 0);
        res_done = 1'b1;
        repeat (40) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
